// File: rtl/vid_stream_pkg.sv
// Shared definitions for the video stream packetizer.
//   vid_state_e    : packetizer FSM states
//   PKT_TYPE_VIDEO : packet-type code carried in the header beat
//   vid_entry_t    : one buffered input word {start, frame_end, data}
package vid_stream_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StHeader = 2'd1,
        StPixels = 2'd2
    } vid_state_e;

    localparam int unsigned PKT_TYPE_VIDEO = 0;

    // Payload width of a buffered entry. The packetizer's DATA_BITS sizes its
    // pixel ports and must equal this value.
    localparam int unsigned VID_DATA_BITS = 31;

    typedef struct packed {
        logic                     start;
        logic                     frame_end;
        logic [VID_DATA_BITS-1:0] data;
    } vid_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and full/empty flags.
// Ports:
//   i_clk, i_reset_n     : clock, asynchronous active-low reset
//   i_wr_en, i_wr_data   : write request and data (ignored while full)
//   i_rd_en              : pop request (ignored while empty)
//   o_rd_data            : head entry, valid while !o_empty
//   o_full, o_empty      : status flags derived from the registered pointers
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // One extra pointer bit separates full from empty when the indices match.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push    = i_wr_en && !o_full;
    assign w_pop     = i_rd_en && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/video_stream_packetizer.sv
// Converts a filtered pixel stream (valid/start/end/data) into Avalon-ST video
// packets: one header beat (type 0, sop) followed by the frame's pixel beats,
// eop on the last. Input words are buffered in a sync_fifo; malformed frames
// are closed early and flagged with a one-cycle frame_err pulse.
// Ports:
//   clk, reset_n                          : clock, asynchronous active-low reset
//   in_valid, in_start, in_end, in_data   : input word and its frame markers
//   out_data, out_valid, out_ready        : output beat and handshake
//   out_sop, out_eop                      : packet delimiters
//   overflow                              : sticky, an input word was dropped
//   frame_err                             : one-cycle pulse on a malformed frame
module video_stream_packetizer
    import vid_stream_pkg::*;
#(
    parameter int unsigned IMAGE_WIDTH  = 320,
    parameter int unsigned IMAGE_HEIGHT = 240,
    parameter int unsigned DATA_BITS    = VID_DATA_BITS,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic                 in_start,
    input  logic                 in_end,
    input  logic [DATA_BITS-1:0] in_data,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sop,
    output logic                 out_eop,
    output logic                 overflow,
    output logic                 frame_err
);

    localparam int unsigned NUM_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int unsigned CNT_BITS   = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [CNT_BITS-1:0] LAST_PIXEL = CNT_BITS'(NUM_PIXELS - 1);

    vid_state_e          r_state;
    vid_state_e          w_state_next;
    logic [CNT_BITS-1:0] r_pix_cnt;
    logic [CNT_BITS-1:0] w_pix_cnt_next;
    logic                r_overflow;
    logic                r_frame_err;
    logic                w_frame_err_next;

    vid_entry_t          w_wr_entry;
    vid_entry_t          w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_rd_en;
    logic                w_last_pixel;
    logic                w_bad_start;
    logic                w_close;

    assign w_wr_entry = '{start: in_start, frame_end: in_end, data: in_data};

    sync_fifo #(
        .WIDTH ($bits(vid_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_wr_en   (in_valid),
        .i_wr_data (w_wr_entry),
        .i_rd_en   (w_rd_en),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // A start flag past the first pixel means the source restarted mid-frame:
    // that word closes the current packet and the new frame is abandoned.
    assign w_last_pixel = (r_pix_cnt == LAST_PIXEL);
    assign w_bad_start  = w_head.start && (r_pix_cnt != '0);
    assign w_close      = w_head.frame_end || w_last_pixel || w_bad_start;

    always_comb begin
        w_state_next     = r_state;
        w_pix_cnt_next   = r_pix_cnt;
        w_rd_en          = 1'b0;
        w_frame_err_next = 1'b0;
        out_valid        = 1'b0;
        out_sop          = 1'b0;
        out_eop          = 1'b0;
        out_data         = '0;
        unique case (r_state)
            StIdle: begin
                // Hunt: discard words until one carries a start flag; that
                // word stays in the FIFO to become the first pixel.
                if (!w_empty) begin
                    if (w_head.start) w_state_next = StHeader;
                    else              w_rd_en      = 1'b1;
                end
            end
            StHeader: begin
                out_valid = 1'b1;
                out_sop   = 1'b1;
                out_data  = DATA_BITS'(PKT_TYPE_VIDEO);
                if (out_ready) begin
                    w_state_next   = StPixels;
                    w_pix_cnt_next = '0;
                end
            end
            StPixels: begin
                if (!w_empty) begin
                    out_valid = 1'b1;
                    out_data  = w_head.data;
                    out_eop   = w_close;
                    if (out_ready) begin
                        w_rd_en        = 1'b1;
                        w_pix_cnt_next = r_pix_cnt + CNT_BITS'(1);
                        if (w_close) begin
                            w_state_next     = StIdle;
                            w_frame_err_next = w_bad_start ||
                                               (w_head.frame_end != w_last_pixel);
                        end
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_pix_cnt   <= '0;
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pix_cnt   <= w_pix_cnt_next;
            r_overflow  <= r_overflow | (in_valid & w_full);
            r_frame_err <= w_frame_err_next;
        end
    end

    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

endmodule

// File: doc/video_stream_packetizer.md
VIDEO_STREAM_PACKETIZER -- requirements
Module: video_stream_packetizer

Interface
REQ-001 Parameter IMAGE_WIDTH, default 320, pixels per line.
REQ-002 Parameter IMAGE_HEIGHT, default 240, lines per frame.
REQ-003 Parameter DATA_BITS, default 31, width of the pixel word, which is carried unmodified.
REQ-004 Parameter FIFO_DEPTH, default 16, input buffer entries; SHALL be a power of 2, at least 4.
REQ-005 clk  input  1  single clock for the whole block.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  qualifies in_start/in_end/in_data for one cycle.
REQ-008 in_start  input  1  first pixel of a frame (filter vga_start).
REQ-009 in_end  input  1  last pixel of a frame (filter vga_end).
REQ-010 in_data  input  DATA_BITS  pixel word (filter vga_data).
REQ-011 out_data  output  DATA_BITS  Avalon-ST video beat.
REQ-012 out_valid  output  1  beat valid.
REQ-013 out_ready  input  1  sink accepts beat.
REQ-014 out_sop  output  1  start of packet, marks the header beat.
REQ-015 out_eop  output  1  end of packet.
REQ-016 overflow  output  1  sticky; set when an input word is dropped.
REQ-017 frame_err  output  1  one-cycle pulse on a malformed frame.

Function
REQ-018 Input write: on in_valid with FIFO not full, push the entry {in_start, in_end, in_data}.
- Full is evaluated before the edge; a same-cycle pop does not admit the write.
REQ-019 Input write, full FIFO: on in_valid with FIFO full, drop the word and set overflow until reset.
REQ-020 Output handshake: a beat transfers on the edge where out_valid and out_ready are both 1.
- While out_valid=1 and out_ready=0, out_data/out_sop/out_eop/out_valid SHALL hold.
REQ-021 FSM states: IDLE, HEADER, PIXELS.
REQ-022 IDLE (hunt):
- Head entry without its start flag: pop and discard it, one per cycle, no output.
- Head entry with its start flag: go to HEADER without popping it.
REQ-023 HEADER: present out_data=0 (packet type 0, video), out_sop=1, out_eop=0.
- On transfer, go to PIXELS with pixel counter = 0.
REQ-024 Header latency: the header beat's out_valid SHALL rise no later than 2 cycles after the start word is written.
REQ-025 PIXELS, normal beat: each beat pops one entry and presents its data with out_sop=0.
- On transfer, pixel counter increments.
- Counter width: clog2(IMAGE_WIDTH*IMAGE_HEIGHT).
REQ-026 PIXELS, end of frame:
- out_eop=1 when the entry's end flag is 1, or when counter = IMAGE_WIDTH*IMAGE_HEIGHT-1.
- After that beat transfers, go to IDLE.
REQ-027 Correct frame: end flag and counter = W*H-1 coincide; frame_err SHALL stay 0.
REQ-028 Early end: end flag with counter < W*H-1 closes the packet (eop=1) and pulses frame_err on the transfer.
REQ-029 Missing end: counter reaches W*H-1 without an end flag; eop=1 is forced and frame_err pulses.
- The next entries are hunted in IDLE.
REQ-030 Mid-frame start: start flag with counter > 0 is output as the final beat with eop=1 and pulses frame_err.
- Go to IDLE; that frame is lost.
REQ-031 Empty FIFO in PIXELS: out_valid=0 and no state change (bubble), never a repeated beat.
REQ-032 Sustained rate: with out_ready held at 1, one pixel beat per cycle.
- No FIFO growth beyond the one header cycle per frame.

Reset
REQ-033 reset_n=0 SHALL asynchronously force the following:
- State = IDLE; FIFO pointers and pixel counter = 0.
- out_valid, out_sop, out_eop, overflow, frame_err = 0; out_data = 0.
REQ-034 Reset mid-frame discards all buffered words.
- After release, the output stays idle until a new start word arrives.

Structure
REQ-035 Shared package vid_stream_pkg holds:
- the FSM state enum;
- the constant PKT_TYPE_VIDEO = 0;
- the FIFO entry struct {start, end, data}.
REQ-036 FIFO buffering is one sub-module, sync_fifo: parameterised width/depth, registered pointers, full/empty flags.
- The packetizer instantiates it once.

Verification (W=4, H=2, FIFO_DEPTH=8)
REQ-037 Good frame:
- Stimulus: 8 consecutive words 0x1..0x8, start on the 1st, end on the 8th, out_ready=1.
- Response: 9 beats, header 0 with sop, data 1..8, eop on 8, frame_err never 1.
REQ-038 Backpressure:
- Stimulus: same frame, out_ready toggled 1/0 each cycle.
- Response: same 9 beats in order; outputs stable during every stall; overflow=0.
REQ-039 Overflow:
- Stimulus: out_ready=0, 10 words written.
- Response: words 9 and 10 dropped; overflow=1 until reset; the first 8 emerge once ready rises.
REQ-040 Early end:
- Stimulus: start on word 1, end on word 5.
- Response: eop on the 5th pixel beat; one frame_err pulse; the next start frame is packetised correctly.
REQ-041 Hunt and mid-frame start:
- Stimulus: 3 words without start, then start frame, then a second start at pixel 3.
- Response: the 3 leading words are never output; eop on the 3rd pixel; frame_err pulses.
REQ-042 Reset mid-frame:
- Stimulus: reset_n low after pixel 4.
- Response: all outputs 0 immediately; no beats after release until the next start word.
